pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the 9-bit CPU.
//  - Holds the 10-bit PC and fetches 9-bit instructions from imem over a req/ack handshake.
//  - Hands each instruction to decode over a valid/ready handshake.
//  - After decode resolves, drives the reg_arithmetic operands (x=pc, incr/jizr/jnzr, v).
//  - Registers reg_arithmetic's res as the next PC. Sits directly upstream of reg_arithmetic.
// PARAMETERS
//  PC_W     10  PC / imem address width; must equal reg_arithmetic width
//  INSTR_W  9   instruction width
//  TMO_CYC  15  imem ack timeout in cycles (used only with FETCH_TIMEOUT_EN)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  start       in   1        1-cycle pulse: load start_addr, begin fetching
//  start_addr  in   PC_W     initial PC
//  imem_req    out  1        fetch request, held until imem_ack
//  imem_addr   out  PC_W     = pc while imem_req
//  imem_ack    in   1        1-cycle: imem_data valid
//  imem_data   in   INSTR_W  fetched instruction
//  instr_valid out  1        instr to decode valid
//  instr       out  INSTR_W  captured instruction
//  dec_ready   in   1        decode accepts instr
//  dec_done    in   1        1-cycle: br_type/br_v/zero_flag valid
//  br_type     in   2        00 seq, 01 jizr, 10 jnzr, 11 halt
//  br_v        in   3        jump distance field
//  zero_flag   in   1        tested register == 0
//  ar_x        out  PC_W     = pc
//  ar_incr/ar_decr/ar_jizr/ar_jnzr  out 1 each  reg_arithmetic op selects; ar_decr tied 0
//  ar_v        out  3        = latched br_v
//  ar_res      in   PC_W     reg_arithmetic result (combinational)
//  pc          out  PC_W     current PC
//  halted      out  1        block in HALT
//  fetch_err   out  1        sticky timeout flag (0 when macro absent)
// BEHAVIOUR
//  - Reset (async): pc=0, all outputs 0, instr=0, state IDLE.
//  - FSM states: IDLE, FETCH, ISSUE, EXEC, UPDATE, HALT.
//  - IDLE/HALT: start -> pc<=start_addr, halted<=0, go FETCH.
//  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_data, go ISSUE.
//    Ack in the same cycle as req entry is legal.
//  - ISSUE: instr_valid=1, held stable; on dec_ready: go EXEC.
//  - EXEC: wait for dec_done.
//    - Latch br_v and take = (br_type==01 & zero_flag) | (br_type==10 & ~zero_flag).
//    - br_type 11: go HALT, pc unchanged.
//    - Otherwise: go UPDATE.
//  - UPDATE (1 cycle): exactly one op select is asserted. If take, ar_jizr or ar_jnzr per br_type; else ar_incr.
//    pc<=ar_res at the end of the cycle, then go FETCH.
//  - Latency: start->first imem_req = 1 cycle. Minimum loop (immediate ack/ready/done) = 4 cycles/instr.
//  - Wrap-around: pc arithmetic is modulo 2^PC_W; 0x3FF+1 -> 0x000.
//  - start while not IDLE/HALT: ignored.
//  - dec_done outside EXEC and imem_ack outside FETCH: ignored.
//  - halted=1 only in HALT.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//    - A counter runs while in FETCH.
//    - TMO_CYC cycles without imem_ack -> fetch_err<=1 (sticky until reset), go HALT.
//  Not defined: FETCH waits indefinitely; fetch_err tied 0; no counter logic.
// STRUCTURE
//  - Shared package cpu_pkg: PC_W, INSTR_W, br_type_e enum (BR_SEQ, BR_JIZR, BR_JNZR, BR_HALT), fetch_state_e.
//  - No sub-modules: reg_arithmetic is instantiated beside this block at CPU top, not inside it.
// TESTING
//  - Reset: assert rst_n=0 mid-FETCH -> all outputs 0 immediately; after release stays IDLE.
//  - start, start_addr=0x010, ack each fetch, br_type=00 x3 -> imem_addr 0x010,0x011,0x012,0x013.
//  - pc=0x020, br_type=01, zero_flag=1, br_v=3 -> ar_jizr=1, ar_v=3, next imem_addr = ar_res from model.
//  - pc=0x020, br_type=10, zero_flag=1 (not taken) -> ar_incr=1, next imem_addr=0x021.
//  - start_addr=0x3FF, br_type=00 -> next imem_addr=0x000. Then br_type=11 -> halted=1, no imem_req.
//  - FETCH_TIMEOUT_EN: withhold imem_ack 15 cycles -> fetch_err=1, halted=1.
//    Without the macro: no error after 100 cycles; ack completes the fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 9-bit CPU: PC/instruction widths, branch
// encodings and the fetch sequencer state type.
package cpu_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int TMO_CYC = 15;

  typedef enum logic [1:0] {
    BR_SEQ  = 2'b00,
    BR_JIZR = 2'b01,
    BR_JNZR = 2'b10,
    BR_HALT = 2'b11
  } br_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } fetch_state_e;

  function automatic logic branch_taken(input br_type_e t, input logic zero_flag);
    return ((t == BR_JIZR) && zero_flag) || ((t == BR_JNZR) && !zero_flag);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory req/ack bus and decode valid/ready/done handshake bundle.
// master = the fetch sequencer, slave = imem plus decode.
interface pc_fetch_ctrl_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               dec_ready;
  logic               dec_done;
  br_type_e           br_type;
  logic [2:0]         br_v;
  logic               zero_flag;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_ack, imem_data, dec_ready, dec_done, br_type, br_v, zero_flag
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_ack, imem_data, dec_ready, dec_done, br_type, br_v, zero_flag
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch/issue/execute sequencer feeding reg_arithmetic.
// Optional imem ack timeout enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int TMO_CYC = cpu_pkg::TMO_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PC_W-1:0]       start_addr,
  pc_fetch_ctrl_if.master       bus,
  output logic [PC_W-1:0]       ar_x,
  output logic                  ar_incr,
  output logic                  ar_decr,
  output logic                  ar_jizr,
  output logic                  ar_jnzr,
  output logic [2:0]            ar_v,
  input  logic [PC_W-1:0]       ar_res,
  output logic [PC_W-1:0]       pc,
  output logic                  halted,
  output logic                  fetch_err
);

  fetch_state_e       state, state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [2:0]         v_q;
  logic               take_q;
  br_type_e           br_q;
  logic               tmo_expired;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      // NOTE: the captured instruction is a single register, not a memory,
      // so resetting it is cheap and keeps instr at 0 out of reset.
      instr_q <= '0;
      v_q     <= '0;
      take_q  <= 1'b0;
      br_q    <= BR_SEQ;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE, S_HALT: if (start) pc <= start_addr;
        S_FETCH:        if (bus.imem_ack) instr_q <= bus.imem_data;
        S_EXEC: if (bus.dec_done) begin
          v_q    <= bus.br_v;
          take_q <= branch_taken(bus.br_type, bus.zero_flag);
          br_q   <= bus.br_type;
        end
        S_UPDATE:       pc <= ar_res;
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // The count restarts on every FETCH entry, so it measures one request's wait.
  assign tmo_expired = (state == S_FETCH) && !bus.imem_ack &&
                       (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == S_FETCH && !bus.imem_ack) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                   tmo_cnt <= '0;
      if (tmo_expired) fetch_err <= 1'b1;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt       = state;
    bus.imem_req    = 1'b0;
    bus.imem_addr   = '0;
    bus.instr_valid = 1'b0;
    ar_incr         = 1'b0;
    ar_jizr         = 1'b0;
    ar_jnzr         = 1'b0;
    halted          = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = pc;
        if (bus.imem_ack)  state_nxt = S_ISSUE;
        else if (tmo_expired) state_nxt = S_HALT;
      end
      S_ISSUE: begin
        bus.instr_valid = 1'b1;
        if (bus.dec_ready) state_nxt = S_EXEC;
      end
      S_EXEC: if (bus.dec_done)
        state_nxt = (bus.br_type == BR_HALT) ? S_HALT : S_UPDATE;
      S_UPDATE: begin
        if (take_q) begin
          ar_jizr = (br_q == BR_JIZR);
          ar_jnzr = (br_q == BR_JNZR);
        end else begin
          ar_incr = 1'b1;
        end
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.instr = instr_q;
  assign ar_x      = pc;
  assign ar_decr   = 1'b0;
  assign ar_v      = v_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with a behavioural
// reg_arithmetic model (incr: x+1, jizr/jnzr: x+v, decr: x-1).
module tb_pc_fetch_ctrl;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] start_addr = '0;
  logic [PC_W-1:0] ar_x, ar_res, pc;
  logic            ar_incr, ar_decr, ar_jizr, ar_jnzr;
  logic [2:0]      ar_v;
  logic            halted, fetch_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .ar_x       (ar_x),
    .ar_incr    (ar_incr),
    .ar_decr    (ar_decr),
    .ar_jizr    (ar_jizr),
    .ar_jnzr    (ar_jnzr),
    .ar_v       (ar_v),
    .ar_res     (ar_res),
    .pc         (pc),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always_comb begin
    ar_res = ar_x;
    if (ar_incr)                ar_res = ar_x + PC_W'(1);
    else if (ar_jizr | ar_jnzr) ar_res = ar_x + PC_W'(ar_v);
    else if (ar_decr)           ar_res = ar_x - PC_W'(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_issue(input string tag, input logic [PC_W-1:0] addr,
                             input logic [INSTR_W-1:0] data);
    for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
    check({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'(addr));
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    tick();
    bus.imem_ack  = 1'b0;
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(bus.instr), 32'(data));
  endtask

  task automatic accept();
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
  endtask

  task automatic resolve(input br_type_e t, input logic zf, input logic [2:0] v);
    bus.dec_done  = 1'b1;
    bus.br_type   = t;
    bus.zero_flag = zf;
    bus.br_v      = v;
    tick();
    bus.dec_done  = 1'b0;
  endtask

  task automatic check_ops(input string tag, input logic incr, input logic jizr, input logic jnzr);
    check({tag, "_ops"}, 32'({ar_incr, ar_jizr, ar_jnzr, ar_decr}),
          32'({incr, jizr, jnzr, 1'b0}));
  endtask

  task automatic do_start(input logic [PC_W-1:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    bus.dec_ready = 1'b0;
    bus.dec_done  = 1'b0;
    bus.br_type   = BR_SEQ;
    bus.br_v      = '0;
    bus.zero_flag = 1'b0;

    tick();
    tick();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a fetch
    do_start(10'h055);
    check("start_latency_req", 32'(bus.imem_req), 32'd1);
    check("start_latency_addr", 32'(bus.imem_addr), 32'h055);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.imem_req), 32'd0);
    check("async_rst_addr", 32'(bus.imem_addr), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_misc", 32'({bus.instr_valid, ar_incr, ar_jizr, ar_jnzr, ar_v, halted}), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("stay_idle_req", 32'(bus.imem_req), 32'd0);
    check("stay_idle_pc", 32'(pc), 32'd0);

    // Sequential fetches from 0x010
    do_start(10'h010);
    fetch_issue("seq0", 10'h010, 9'h101);
    accept();
    resolve(BR_SEQ, 1'b0, 3'd0);
    check_ops("seq0", 1'b1, 1'b0, 1'b0);
    check("seq0_x", 32'(ar_x), 32'h010);
    tick();
    fetch_issue("seq1", 10'h011, 9'h102);
    accept();
    resolve(BR_SEQ, 1'b1, 3'd7);
    check_ops("seq1", 1'b1, 1'b0, 1'b0);
    tick();
    fetch_issue("seq2", 10'h012, 9'h103);
    accept();
    resolve(BR_SEQ, 1'b0, 3'd0);
    tick();
    fetch_issue("seq3", 10'h013, 9'h0F3);

    // Stray ack and dec_done while issuing must be ignored
    bus.imem_ack  = 1'b1;
    bus.imem_data = 9'h1AA;
    bus.dec_done  = 1'b1;
    bus.br_type   = BR_HALT;
    tick();
    bus.imem_ack  = 1'b0;
    bus.dec_done  = 1'b0;
    check("stray_valid", 32'(bus.instr_valid), 32'd1);
    check("stray_instr", 32'(bus.instr), 32'h0F3);
    check("stray_halted", 32'(halted), 32'd0);
    accept();
    resolve(BR_HALT, 1'b0, 3'd0);
    check("halt0_halted", 32'(halted), 32'd1);
    check("halt0_req", 32'(bus.imem_req), 32'd0);
    check("halt0_pc", 32'(pc), 32'h013);

    // jizr taken: 0x020 + 3 = 0x023
    do_start(10'h020);
    check("restart_halted", 32'(halted), 32'd0);
    fetch_issue("jizr", 10'h020, 9'h041);
    accept();
    resolve(BR_JIZR, 1'b1, 3'd3);
    check_ops("jizr", 1'b0, 1'b1, 1'b0);
    check("jizr_v", 32'(ar_v), 32'd3);
    check("jizr_x", 32'(ar_x), 32'h020);
    tick();
    fetch_issue("jizr_tgt", 10'h023, 9'h000);
    accept();
    resolve(BR_HALT, 1'b0, 3'd0);

    // jnzr not taken, jnzr taken (+5), jizr not taken
    do_start(10'h020);
    fetch_issue("jnzr_nt", 10'h020, 9'h081);
    accept();
    resolve(BR_JNZR, 1'b1, 3'd3);
    check_ops("jnzr_nt", 1'b1, 1'b0, 1'b0);
    tick();
    fetch_issue("jnzr_t", 10'h021, 9'h085);
    accept();
    resolve(BR_JNZR, 1'b0, 3'd5);
    check_ops("jnzr_t", 1'b0, 1'b0, 1'b1);
    check("jnzr_t_v", 32'(ar_v), 32'd5);
    tick();
    fetch_issue("jizr_nt", 10'h026, 9'h042);
    accept();
    resolve(BR_JIZR, 1'b0, 3'd2);
    check_ops("jizr_nt", 1'b1, 1'b0, 1'b0);
    tick();
    fetch_issue("jizr_nt_tgt", 10'h027, 9'h000);
    accept();
    resolve(BR_HALT, 1'b0, 3'd0);

    // Wrap-around from 0x3FF, with an ignored start while fetching
    do_start(10'h3FF);
    do_start(10'h100);
    check("start_ignored_pc", 32'(pc), 32'h3FF);
    fetch_issue("wrap", 10'h3FF, 9'h000);
    accept();
    resolve(BR_SEQ, 1'b0, 3'd0);
    check_ops("wrap", 1'b1, 1'b0, 1'b0);
    tick();
    fetch_issue("wrap_tgt", 10'h000, 9'h1C0);
    accept();
    resolve(BR_HALT, 1'b0, 3'd0);
    check("wrap_halted", 32'(halted), 32'd1);
    tick();
    tick();
    tick();
    check("halt_no_req", 32'(bus.imem_req), 32'd0);
    check("halt_pc_kept", 32'(pc), 32'h000);

    // Withheld imem_ack
    do_start(10'h005);
`ifdef FETCH_TIMEOUT_EN
    repeat (14) tick();
    check("tmo_pre_req", 32'(bus.imem_req), 32'd1);
    check("tmo_pre_err", 32'(fetch_err), 32'd0);
    tick();
    check("tmo_err", 32'(fetch_err), 32'd1);
    check("tmo_halted", 32'(halted), 32'd1);
    check("tmo_no_req", 32'(bus.imem_req), 32'd0);
`else
    repeat (100) tick();
    check("wait_req", 32'(bus.imem_req), 32'd1);
    check("wait_err", 32'(fetch_err), 32'd0);
    check("wait_halted", 32'(halted), 32'd0);
    fetch_issue("late_ack", 10'h005, 9'h155);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
